// File: rtl/gates_unit.sv
// Registered seven-lane gate unit: each output lane applies a fixed two-input
// Boolean function to a[i]/b[i]. Optional even-parity output under GATES_PARITY_EN.
module gates_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic [6:0] z
`ifdef GATES_PARITY_EN
  ,
  output logic       z_par
`endif
);

  function automatic logic even_parity(input logic [6:0] v);
    return ^v;
  endfunction

  logic [6:0] z_next_s;
  logic [6:0] z_r;

  // Per-lane gate functions; lane 6 inverts a and deliberately ignores b[6].
  always_comb begin
    z_next_s    = 7'h00;
    z_next_s[0] = a[0] & b[0];
    z_next_s[1] = a[1] | b[1];
    z_next_s[2] = ~(a[2] & b[2]);
    z_next_s[3] = ~(a[3] | b[3]);
    z_next_s[4] = a[4] ^ b[4];
    z_next_s[5] = ~(a[5] ^ b[5]);
    z_next_s[6] = ~a[6];
  end

  // Result register: loads every edge; reset value is all-zero, not f(0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_r <= 7'h00;
    end else begin
      z_r <= z_next_s;
    end
  end

  assign z = z_r;

`ifdef GATES_PARITY_EN
  logic z_par_r;

  // Parity taken from the next-state bits so it lines up with z each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_par_r <= 1'b0;
    end else begin
      z_par_r <= even_parity(z_next_s);
    end
  end

  assign z_par = z_par_r;
`endif

endmodule

// File: tb/tb_gates_unit.sv
// Self-checking bench for gates_unit: directed plan plus randomized stimulus
// against a truth-table reference model.
module tb_gates_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] a;
  logic [6:0] b;
  logic [6:0] z;
  logic       z_par;

  int n_checks;
  int n_fails;

  // Truth table per lane, indexed by {a_bit, b_bit}.
  logic [3:0] lane_tt [7];

  gates_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .z    (z)
`ifdef GATES_PARITY_EN
    ,
    .z_par(z_par)
`endif
  );

`ifndef GATES_PARITY_EN
  assign z_par = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_z(input logic [6:0] ma, input logic [6:0] mb);
    logic [6:0] r;
    int idx;
    r = 7'h00;
    for (int i = 0; i < 7; i++) begin
      idx  = int'(ma[i]) * 2 + int'(mb[i]);
      r[i] = lane_tt[i][idx];
    end
    return r;
  endfunction

  function automatic logic model_par(input logic [6:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += int'(v[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic check_out(input string tag, input logic [6:0] exp_z);
    check_val(tag, {1'b0, z}, {1'b0, exp_z});
`ifdef GATES_PARITY_EN
    check_val({tag, "_par"}, {7'h00, z_par}, {7'h00, model_par(exp_z)});
`endif
  endtask

  // Drive operands, take one edge, then sample 1 time unit later.
  task automatic step(input string tag, input logic [6:0] va, input logic [6:0] vb);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    check_out(tag, model_z(va, vb));
  endtask

  initial begin
    logic [6:0] ra;
    logic [6:0] rb;
    n_checks = 0;
    n_fails  = 0;
    lane_tt[0] = 4'b1000;  // AND
    lane_tt[1] = 4'b1110;  // OR
    lane_tt[2] = 4'b0111;  // NAND
    lane_tt[3] = 4'b0001;  // NOR
    lane_tt[4] = 4'b0110;  // XOR
    lane_tt[5] = 4'b1001;  // XNOR
    lane_tt[6] = 4'b0011;  // NOT a

    rst_n = 1'b0;
    a = 7'h7F;
    b = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_z", {1'b0, z}, 8'h00);
    check_val("reset_par", {7'h00, z_par}, 8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    a = 7'h00;
    b = 7'h00;
    @(posedge clk);
    #1;
    check_val("zero_in", {1'b0, z}, 8'h6C);
    check_out("zero_in_model", model_z(7'h00, 7'h00));

    step("a1_b0", 7'h7F, 7'h00);
    check_val("a1_b0_const", {1'b0, z}, 8'h16);
    step("a1_b1", 7'h7F, 7'h7F);
    check_val("a1_b1_const", {1'b0, z}, 8'h23);
    step("a0_b1", 7'h00, 7'h7F);
    check_val("a0_b1_const", {1'b0, z}, 8'h56);
    step("b6_toggle", 7'h00, 7'h3F);
    check_val("b6_ignored", {7'h00, z[6]}, 8'h01);

    for (int i = 0; i < 128; i++) begin
      ra = 7'(i);
      step("sweep", ra, ~ra);
    end

    for (int i = 0; i < 300; i++) begin
      ra = 7'($urandom_range(127, 0));
      rb = 7'($urandom_range(127, 0));
      step("random", ra, rb);
    end

    step("pre_rst", 7'h7F, 7'h7F);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_z", {1'b0, z}, 8'h00);
    check_val("midrst_par", {7'h00, z_par}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    a = 7'h7F;
    b = 7'h00;
    #1;
    check_val("post_rst_hold", {1'b0, z}, 8'h00);
    @(posedge clk);
    #1;
    check_out("post_rst_first", model_z(7'h7F, 7'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gates_unit.md
# gates_unit

Registered seven-lane logic-gate unit. Each bit lane of the 7-bit output applies a different fixed two-input Boolean function to the corresponding bits of operands `a` and `b`. The output is captured on every rising clock edge. It is the basic gate-primitive block exercised at the bottom of the design hierarchy and feeds downstream logic as a registered 7-bit result bus.

## Interface
Parameters:
- none; the lane width is fixed at 7, one lane per gate function.

Ports:
- `clk` input 1 — single system clock; all state updates on the rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `a` input 7 — operand A, one bit per lane.
- `b` input 7 — operand B, one bit per lane.
- `z` output 7 — registered gate results, one bit per lane.
- `z_par` output 1 — registered even-parity bit of `z`; present only with `GATES_PARITY_EN`.

## Operation
Lane i is computed from `a[i]` and `b[i]` only:
- `z[0]` = a AND b
- `z[1]` = a OR b
- `z[2]` = a NAND b
- `z[3]` = a NOR b
- `z[4]` = a XOR b
- `z[5]` = a XNOR b
- `z[6]` = NOT a; `b[6]` is ignored.

Additional rules:
- There is no cross-lane dependency. Lanes are purely bitwise, with no carries and no arithmetic.
- The next-state value is computed combinationally from the current `a` and `b`. It is loaded into the `z` register on every clock edge; there is no enable and no hold.
- X or Z inputs propagate per standard Verilog gate semantics. No sanitising is done.

## Timing
- Latency is 1 cycle. `a` and `b` sampled at rising edge N appear on `z` immediately after edge N.
- Throughput is one new result per cycle. There is no handshake, and new inputs may change every cycle.
- While `rst_n` is low, `z` is 7'h00 and `z_par` is 0.
  - This holds regardless of `clk`, and the reset takes effect immediately (asynchronous).
  - The reset value is not the gate function of zero inputs. Gate function of a=b=0 would be 7'h6C; reset forces 7'h00.
- Reset deassertion is treated as synchronous to `clk` by the integrator. The first capture occurs on the first rising edge after `rst_n` goes high.
- If reset asserts mid-stream, the output clears at once. Any in-flight result is discarded; there is no recovery of the lost value.
- Outputs are glitch-free: they change only on a clock edge or on reset assertion.

## Configuration
- Macro: `GATES_PARITY_EN`.
- Defined:
  - Port `z_par` exists.
  - `z_par` is registered alongside `z` and equals the XOR of the next-state `z` bits, so it is consistent with `z` on the same cycle.
  - `z_par` resets to 0.
- Undefined:
  - Port `z_par` and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset check: hold `rst_n`=0 with a=7'h7F, b=7'h7F and toggle `clk` -> z=7'h00 (z_par=0).
- Release reset, drive a=7'h00, b=7'h00 -> after one rising edge z=7'h6C (z_par=0).
- Drive a=7'h7F, b=7'h00 -> next edge z=7'h16 (z_par=1). Then a=7'h7F, b=7'h7F -> next edge z=7'h23 (z_par=1).
- Drive a=7'h00, b=7'h7F -> next edge z=7'h56 (z_par=0). Toggling `b[6]` alone leaves `z[6]` unchanged.
- Back-to-back: change a/b every cycle across all 128 values of a with b=~a -> each z matches the per-lane equations exactly one cycle later. There are no dropped or duplicated results.
- Mid-stream reset: assert `rst_n`=0 between edges while z=7'h23 -> z=7'h00 immediately without a clock edge. After release, the first edge loads the current inputs.
